addsub_sequencer: RTL and testbench

ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

---
 rtl/addsub_sequencer.sv | 158 +++++++++++++++
 tb/tb_addsub_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/addsub_sequencer.sv
// Pushbutton-driven 16-bit add/subtract sequencer: debounced Enter steps through
// operand A capture, operand B capture, one-cycle compute and a chained result display.
module addsub_sequencer #(
    parameter int DB_CYCLES = 50000,
    parameter int WIDTH     = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enter,
    input  logic             Op,
    input  logic [WIDTH-1:0] SW,
    output logic [3:0]       HEX3,
    output logic [3:0]       HEX2,
    output logic [3:0]       HEX1,
    output logic [3:0]       HEX0,
    output logic             Load,
    output logic             Carry,
    output logic             Overflow,
    output logic [1:0]       State
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        CALC  = 2'd2,
        SHOW  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic             sync1_reg, sync2_reg;
    logic             db_level_reg, db_prev_reg;
    logic [CW-1:0]    db_count_reg;
    logic             enter_pulse;

    logic [WIDTH-1:0] a_reg, b_reg, result_reg, disp_reg;
    logic             op_reg, carry_reg, ovf_reg, load_reg;

    logic             load_a, load_b, do_calc, load_show, disp_we;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf;

    // Synchronizer plus debounce: level flips only after DB_CYCLES consecutive mismatches.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            db_level_reg <= 1'b0;
            db_prev_reg  <= 1'b0;
            db_count_reg <= '0;
        end else begin
            sync1_reg   <= Enter;
            sync2_reg   <= sync1_reg;
            db_prev_reg <= db_level_reg;
            if (sync2_reg != db_level_reg) begin
                if (db_count_reg == CW'(DB_CYCLES - 1)) begin
                    db_level_reg <= sync2_reg;
                    db_count_reg <= '0;
                end else begin
                    db_count_reg <= db_count_reg + CW'(1);
                end
            end else begin
                db_count_reg <= '0;
            end
        end
    end

    assign enter_pulse = db_level_reg & ~db_prev_reg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_reg <= GET_A;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            GET_A:   if (enter_pulse) state_next = GET_B;
            GET_B:   if (enter_pulse) state_next = CALC;
            CALC:    state_next = SHOW;
            SHOW:    if (enter_pulse) state_next = GET_B;
            default: state_next = GET_A;
        endcase
    end

    always_comb begin
        load_a    = 1'b0;
        load_b    = 1'b0;
        do_calc   = 1'b0;
        load_show = 1'b0;
        case (state_reg)
            GET_A:   load_a    = enter_pulse;
            GET_B:   load_b    = enter_pulse;
            CALC:    do_calc   = 1'b1;
            SHOW:    load_show = enter_pulse;
            default: ;
        endcase
        disp_we = load_a | load_b | do_calc | load_show;
    end

    // Subtract is A + ~B + 1, so bit WIDTH is carry for add and not-borrow for subtract.
    assign b_eff = op_reg ? ~b_reg : b_reg;
    assign sum   = {1'b0, a_reg} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_reg};
    assign ovf   = (a_reg[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= 1'b0;
            result_reg <= '0;
            disp_reg   <= '0;
            carry_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            load_reg   <= 1'b0;
        end else begin
            load_reg <= disp_we;
            if (load_a) begin
                a_reg    <= SW;
                disp_reg <= SW;
            end
            if (load_b) begin
                b_reg    <= SW;
                op_reg   <= Op;
                disp_reg <= SW;
            end
            if (do_calc) begin
                result_reg <= sum[WIDTH-1:0];
                disp_reg   <= sum[WIDTH-1:0];
                carry_reg  <= sum[WIDTH];
                ovf_reg    <= ovf;
            end
            if (load_show) begin
                a_reg    <= result_reg;
                disp_reg <= result_reg;
            end
        end
    end

    logic [3:0] nib [4];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign nib[gi] = disp_reg[gi*4 +: 4];
        end
    endgenerate

    assign HEX0     = nib[0];
    assign HEX1     = nib[1];
    assign HEX2     = nib[2];
    assign HEX3     = nib[3];
    assign Load     = load_reg;
    assign Carry    = carry_reg;
    assign Overflow = ovf_reg;
    assign State    = state_reg;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed bench for addsub_sequencer with a short debounce window; each press
// is a transaction whose Load count, display and flags are compared to hand values.
module tb_addsub_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Enter = 1'b0;
    logic        Op    = 1'b0;
    logic [15:0] SW    = 16'h0000;
    logic [3:0]  HEX3, HEX2, HEX1, HEX0;
    logic        Load, Carry, Overflow;
    logic [1:0]  State;

    int checks   = 0;
    int failures = 0;

    addsub_sequencer #(.DB_CYCLES(4), .WIDTH(16)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Enter    (Enter),
        .Op       (Op),
        .SW       (SW),
        .HEX3     (HEX3),
        .HEX2     (HEX2),
        .HEX1     (HEX1),
        .HEX0     (HEX0),
        .Load     (Load),
        .Carry    (Carry),
        .Overflow (Overflow),
        .State    (State)
    );

    always #5 Clock = ~Clock;

    wire [15:0] hex = {HEX3, HEX2, HEX1, HEX0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        Enter = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic idle(input int n, inout int loads);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            if (Load) loads++;
        end
    endtask

    // Clean press: hold long enough to debounce, then release long enough to settle.
    task automatic press(input logic [15:0] sw, input logic op, output int loads);
        loads = 0;
        SW = sw;
        Op = op;
        Enter = 1'b1;
        idle(12, loads);
        Enter = 1'b0;
        idle(12, loads);
        $display("txn press sw=%h op=%0d loads=%0d hex=%h state=%0d c=%0d v=%0d",
                 sw, op, loads, hex, State, Carry, Overflow);
    endtask

    initial begin
        int  loads;
        bit  found;

        // Reset state
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("rst_hex", hex, 16'h0000);
        check("rst_load", Load, 1'b0);
        check("rst_state", State, 2'd0);
        check("rst_carry", Carry, 1'b0);
        check("rst_ovf", Overflow, 1'b0);

        // 0x1234 + 0x0FFF
        press(16'h1234, 1'b0, loads);
        check("a1_loads", loads, 1);
        check("a1_hex", hex, 16'h1234);
        check("a1_state", State, 2'd1);
        press(16'h0FFF, 1'b0, loads);
        check("b1_loads", loads, 2);
        check("b1_hex", hex, 16'h2233);
        check("b1_carry", Carry, 1'b0);
        check("b1_ovf", Overflow, 1'b0);
        check("b1_state", State, 2'd3);

        // 0x7FFF + 0x0001 overflows positive to negative
        do_reset();
        press(16'h7FFF, 1'b0, loads);
        press(16'h0001, 1'b0, loads);
        check("ov_loads", loads, 2);
        check("ov_hex", hex, 16'h8000);
        check("ov_ovf", Overflow, 1'b1);
        check("ov_carry", Carry, 1'b0);

        // 0x0003 - 0x0005 borrows
        do_reset();
        press(16'h0003, 1'b1, loads);
        press(16'h0005, 1'b1, loads);
        check("sub_hex", hex, 16'hFFFE);
        check("sub_carry", Carry, 1'b0);
        check("sub_ovf", Overflow, 1'b0);

        // Chain: 0x000C + 0x0004 = 0x0010, then 0x0010 - 0x0001
        do_reset();
        press(16'h000C, 1'b0, loads);
        press(16'h0004, 1'b0, loads);
        check("ch0_hex", hex, 16'h0010);
        press(16'hBEEF, 1'b1, loads);
        check("ch1_loads", loads, 1);
        check("ch1_hex", hex, 16'h0010);
        check("ch1_state", State, 2'd1);
        check("ch1_carry_hold", Carry, 1'b0);
        press(16'h0001, 1'b1, loads);
        check("ch2_hex", hex, 16'h000F);
        check("ch2_carry", Carry, 1'b1);
        check("ch2_ovf", Overflow, 1'b0);

        // Bounce: toggle every 2 cycles for 20 cycles, then hold high
        do_reset();
        SW = 16'hABCD;
        loads = 0;
        for (int i = 0; i < 10; i++) begin
            Enter = ~Enter;
            idle(2, loads);
        end
        check("bnc_noload", loads, 0);
        Enter = 1'b1;
        idle(12, loads);
        Enter = 1'b0;
        idle(12, loads);
        $display("txn bounce loads=%0d hex=%h state=%0d", loads, hex, State);
        check("bnc_loads", loads, 1);
        check("bnc_hex", hex, 16'hABCD);
        check("bnc_state", State, 2'd1);

        // Reset during CALC: B captured, abort before the result lands
        SW = 16'h1111;
        Op = 1'b0;
        Enter = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge Clock);
            if (State == 2'd2) found = 1'b1;
        end
        check("calc_reached", found, 1'b1);
        Reset = 1'b1;
        #1;
        check("rc_load", Load, 1'b0);
        check("rc_hex", hex, 16'h0000);
        check("rc_state", State, 2'd0);
        check("rc_carry", Carry, 1'b0);
        Enter = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        loads = 0;
        idle(20, loads);
        $display("txn reset_in_calc loads=%0d hex=%h state=%0d", loads, hex, State);
        check("rc_noload", loads, 0);
        check("rc_wait", State, 2'd0);

        // Enter held across reset release: one capture after a fresh debounce
        SW = 16'h5A5A;
        Enter = 1'b1;
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        loads = 0;
        idle(3, loads);
        check("hold_early", loads, 0);
        idle(17, loads);
        Enter = 1'b0;
        idle(12, loads);
        $display("txn held_over_reset loads=%0d hex=%h state=%0d", loads, hex, State);
        check("hold_loads", loads, 1);
        check("hold_hex", hex, 16'h5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
